// File: rtl/prio_arb_hold_pkg.sv
// Shared definitions for the render-path hold arbiter: mode codes, FSM state
// constants and small helpers used by the interface and the RTL.
package prio_arb_hold_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    // Width of the hold counter: wide enough for MAX_HOLD, never narrower than 1 bit.
    function automatic int hold_cnt_width(input int max_hold);
        int w;
        w = $clog2(max_hold + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = idx | 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/prio_arb_hold_if.sv
// Request/grant bundle between render clients (master) and the arbiter (slave).
interface prio_arb_hold_if
    import prio_arb_hold_pkg::*;
#(
    parameter int N_REQ    = 10,
    parameter int MAX_HOLD = 0
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int HC_W  = hold_cnt_width(MAX_HOLD);

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] gnt;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic [HC_W-1:0]  hold_cnt;

    modport master (
        output req, done,
        input  gnt, gnt_valid, gnt_idx, hold_cnt
    );

    modport slave (
        input  req, done,
        output gnt, gnt_valid, gnt_idx, hold_cnt
    );

endinterface

// File: rtl/prio_arb_hold_msb_pick_rot.sv
// Combinational descending search with wrap: the first set request at or below
// start_idx wins, continuing from N_REQ-1 down to just above start_idx.
module msb_pick_rot #(
    parameter int N_REQ = 10,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start_idx,
    output logic [N_REQ-1:0] win,
    output logic             found
);

    int pos;

    always_comb begin
        win   = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = int'(start_idx) - i;
            if (pos < 0) begin
                pos = pos + N_REQ;
            end
            if (!found && req[IDX_W'(pos)]) begin
                win[IDX_W'(pos)] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_arb_hold.sv
// Registered fixed/round-robin arbiter that holds each grant until done,
// request drop or hold timeout, handing over back-to-back when possible.
module prio_arb_hold
    import prio_arb_hold_pkg::*;
#(
    parameter int N_REQ    = 10,
    parameter int MODE     = MODE_FIXED,
    parameter int MAX_HOLD = 0,
    localparam int IDX_W   = $clog2(N_REQ)
) (
    input  logic           clk,
    input  logic           rst_n,
    prio_arb_hold_if.slave bus
);

    localparam int HC_W = hold_cnt_width(MAX_HOLD);

    logic [0:0]       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;

    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W-1:0] start_idx;
    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] win;
    logic             found;
    logic             timeout;
    logic             rel_evt;
    logic             load;

    assign cur_idx = IDX_W'(onehot_to_idx(32'(gnt_q)));

    // The releasing client sits out the decision made in its release cycle.
    assign cand    = bus.req & ~gnt_q;
    assign timeout = (MAX_HOLD != 0) && (hold_cnt_q == HC_W'(MAX_HOLD));
    assign rel_evt = (state_q == GRANT) && (bus.done || !bus.req[cur_idx] || timeout);

    assign start_idx = (MODE == MODE_FIXED || ptr_q == '0) ? IDX_W'(N_REQ - 1)
                                                           : ptr_q - 1'b1;

    msb_pick_rot #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req       (cand),
        .start_idx (start_idx),
        .win       (win),
        .found     (found)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        load       = 1'b0;
        case (state_q)
            IDLE: begin
                load = found;
            end
            GRANT: begin
                if (rel_evt) begin
                    if (found) begin
                        load = 1'b1;
                    end else begin
                        gnt_d      = '0;
                        hold_cnt_d = '0;
                        state_d    = IDLE;
                    end
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                gnt_d      = '0;
                hold_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase
        if (load) begin
            gnt_d      = win;
            hold_cnt_d = HC_W'(1);
            ptr_d      = IDX_W'(onehot_to_idx(32'(win)));
            state_d    = GRANT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = |gnt_q;
    assign bus.gnt_idx   = cur_idx;
    assign bus.hold_cnt  = hold_cnt_q;

endmodule

// File: tb/tb_prio_arb_hold.sv
// Directed bench for prio_arb_hold: fixed, round-robin and timeout variants
// share one stimulus source and are reset at the start of each scenario.
module tb_prio_arb_hold;

    logic       clk;
    logic       rst_n;
    logic [9:0] req;
    logic       done;

    int vectors;
    int errors;

    prio_arb_hold_if #(.N_REQ(10), .MAX_HOLD(0)) if_fix ();
    prio_arb_hold_if #(.N_REQ(10), .MAX_HOLD(0)) if_rr ();
    prio_arb_hold_if #(.N_REQ(10), .MAX_HOLD(4)) if_to ();

    assign if_fix.req  = req;
    assign if_fix.done = done;
    assign if_rr.req   = req;
    assign if_rr.done  = done;
    assign if_to.req   = req;
    assign if_to.done  = done;

    prio_arb_hold #(.N_REQ(10), .MODE(0), .MAX_HOLD(0)) dut_fix (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_fix.slave)
    );

    prio_arb_hold #(.N_REQ(10), .MODE(1), .MAX_HOLD(0)) dut_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_rr.slave)
    );

    prio_arb_hold #(.N_REQ(10), .MODE(0), .MAX_HOLD(4)) dut_to (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_to.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = '0;
        done  = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (if_fix.gnt !== 10'h000 || if_fix.gnt_valid !== 1'b0 || if_fix.gnt_idx !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_fix: gnt=%h valid=%b idx=%0d, want 000/0/0",
                     if_fix.gnt, if_fix.gnt_valid, if_fix.gnt_idx);
        end
        vectors++;
        if (if_to.gnt !== 10'h000 || if_to.hold_cnt !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_to: gnt=%h hold=%0d, want 000/0", if_to.gnt, if_to.hold_cnt);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        vectors++;
        if (if_fix.gnt !== 10'h000 || if_fix.gnt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_done: gnt=%h valid=%b, want 000/0", if_fix.gnt, if_fix.gnt_valid);
        end
    endtask

    task automatic test_fixed_handover();
        do_reset();
        req = 10'b11_0000_0001;
        for (int c = 1; c <= 5; c++) begin
            tick();
            vectors++;
            if (if_fix.gnt !== 10'h200 || if_fix.gnt_idx !== 4'd9 || if_fix.gnt_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL fix_hold c%0d: gnt=%h idx=%0d, want 200/9", c, if_fix.gnt, if_fix.gnt_idx);
            end
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        vectors++;
        if (if_fix.gnt !== 10'h100 || if_fix.gnt_idx !== 4'd8 || if_fix.gnt_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fix_handover: gnt=%h idx=%0d valid=%b, want 100/8/1",
                     if_fix.gnt, if_fix.gnt_idx, if_fix.gnt_valid);
        end
    endtask

    task automatic test_round_robin();
        int exp_idx;
        do_reset();
        req  = 10'h3FF;
        done = 1'b1;
        exp_idx = 9;
        for (int c = 0; c < 11; c++) begin
            tick();
            vectors++;
            if (if_rr.gnt_idx !== 4'(exp_idx) || if_rr.gnt !== (10'h001 << exp_idx)) begin
                errors++;
                $display("[TB] FAIL rr_seq c%0d: gnt=%h idx=%0d, want idx %0d",
                         c, if_rr.gnt, if_rr.gnt_idx, exp_idx);
            end
            exp_idx = (exp_idx == 0) ? 9 : exp_idx - 1;
        end
        done = 1'b0;
    endtask

    task automatic test_timeout();
        int seq [3];
        seq = '{9, 3, 9};
        do_reset();
        req = 10'h208;
        for (int g = 0; g < 3; g++) begin
            for (int h = 1; h <= 4; h++) begin
                tick();
                vectors++;
                if (if_to.gnt_idx !== 4'(seq[g]) || if_to.hold_cnt !== 3'(h)) begin
                    errors++;
                    $display("[TB] FAIL timeout g%0d h%0d: idx=%0d hold=%0d, want idx %0d hold %0d",
                             g, h, if_to.gnt_idx, if_to.hold_cnt, seq[g], h);
                end
            end
        end
    endtask

    task automatic test_req_drop();
        do_reset();
        req = 10'h020;
        tick();
        vectors++;
        if (if_fix.gnt !== 10'h020 || if_fix.gnt_idx !== 4'd5) begin
            errors++;
            $display("[TB] FAIL drop_grant: gnt=%h idx=%0d, want 020/5", if_fix.gnt, if_fix.gnt_idx);
        end
        req = 10'h000;
        tick();
        vectors++;
        if (if_fix.gnt !== 10'h000 || if_fix.gnt_valid !== 1'b0 || if_fix.gnt_idx !== 4'd0) begin
            errors++;
            $display("[TB] FAIL drop_release: gnt=%h valid=%b idx=%0d, want 000/0/0",
                     if_fix.gnt, if_fix.gnt_valid, if_fix.gnt_idx);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 10'h004;
        tick();
        vectors++;
        if (if_fix.gnt !== 10'h004) begin
            errors++;
            $display("[TB] FAIL b2b_first: gnt=%h, want 004", if_fix.gnt);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        vectors++;
        if (if_fix.gnt !== 10'h000 || if_fix.gnt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_bubble: gnt=%h valid=%b, want 000/0", if_fix.gnt, if_fix.gnt_valid);
        end
        tick();
        vectors++;
        if (if_fix.gnt !== 10'h004 || if_fix.gnt_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_regrant: gnt=%h valid=%b, want 004/1", if_fix.gnt, if_fix.gnt_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req  = 10'h3FF;
        done = 1'b1;
        tick();
        tick();
        tick();
        done = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (if_fix.gnt !== 10'h000 || if_rr.gnt !== 10'h000 || if_rr.gnt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: fix=%h rr=%h rr_valid=%b, want 000/000/0",
                     if_fix.gnt, if_rr.gnt, if_rr.gnt_valid);
        end
        tick();
        vectors++;
        if (if_rr.gnt !== 10'h000 || if_to.hold_cnt !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_held: rr=%h hold=%0d, want 000/0", if_rr.gnt, if_to.hold_cnt);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (if_rr.gnt !== 10'h200 || if_rr.gnt_idx !== 4'd9) begin
            errors++;
            $display("[TB] FAIL rr_after_reset: gnt=%h idx=%0d, want 200/9", if_rr.gnt, if_rr.gnt_idx);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst_n   = 1'b0;
        req     = '0;
        done    = 1'b0;
        tick();
        test_reset();
        test_fixed_handover();
        test_round_robin();
        test_timeout();
        test_req_drop();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
